// File: rtl/raw_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : raw_buffer
// Brief   : Circular word buffer that is read out in whole blocks of wblock+1
//           words. Defining RAW_BUFFER_OVF_CNT_EN builds a saturating counter
//           of dropped writes.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module raw_buffer #(
  parameter int DW     = 672,
  parameter int AW     = 8,
  parameter int MARGIN = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] dw,
  input  logic [AW-1:0] wblock,
  input  logic          rd_start,
  output logic [DW-1:0] dr,
  output logic          rd_valid,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] occ,
  output logic [15:0]   ovf_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  localparam int TW = AW + 2;

  state_t        state_q;
  logic [AW-1:0] adw_q;
  logic [AW-1:0] adb_q;
  logic [AW-1:0] adrr_q;
  logic [AW-1:0] adrr_d;
  logic [AW-1:0] bc_q;
  logic [AW-1:0] blen_q;
  logic [DW-1:0] dr_q;

  logic [DW-1:0] mem [2**AW];

  logic [AW-1:0] w_diff;
  logic [AW-1:0] w_occ;
  logic [TW-1:0] w_thr;
  logic          w_full;
  logic          w_wr_en;
  logic          w_start;
  logic          w_last;

  // Threshold is evaluated two bits wider so wblock+MARGIN never wraps.
  assign w_diff  = adb_q - adw_q;
  assign w_occ   = adw_q - adb_q;
  assign w_thr   = {2'b00, wblock} + TW'(MARGIN);
  assign w_full  = !(({2'b00, w_diff} > w_thr) || (adb_q == adw_q));
  assign w_wr_en = we && !w_full && !rst;
  assign w_start = (state_q == S_IDLE) && rd_start &&
                   ({1'b0, w_occ} >= ({1'b0, wblock} + (AW+1)'(1)));
  assign w_last  = (state_q == S_READ) && (bc_q == blen_q);

  always_comb begin
    adrr_d = adrr_q;
    if (rst) begin
      adrr_d = '0;
    end else if (w_start) begin
      adrr_d = adb_q;
    end else if (state_q == S_READ) begin
      adrr_d = adrr_q + AW'(1);
    end
  end

  // Registered read of the next address keeps dr == mem[adrr_q] with RAM timing.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem[adw_q] <= dw;
    end
    dr_q <= mem[adrr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      adw_q   <= '0;
      adb_q   <= '0;
      adrr_q  <= '0;
      bc_q    <= '0;
      blen_q  <= '0;
    end else begin
      adrr_q <= adrr_d;
      if (w_wr_en) begin
        adw_q <= adw_q + AW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (w_start) begin
            blen_q  <= wblock;
            bc_q    <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          bc_q <= bc_q + AW'(1);
          if (w_last) begin
            adb_q   <= adb_q + blen_q + AW'(1);
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef RAW_BUFFER_OVF_CNT_EN
  logic [15:0] ovf_q;
  logic        w_drop;

  assign w_drop = we && w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (w_drop && (ovf_q != 16'hFFFF)) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

  assign dr       = dr_q;
  assign rd_valid = (state_q == S_READ);
  assign busy     = (state_q == S_READ);
  assign full     = w_full;
  assign empty    = (adw_q == adb_q);
  assign occ      = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_raw_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_raw_buffer
// Brief   : Directed self-checking bench for raw_buffer at default parameters.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_raw_buffer;

  localparam int DW = 672;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          we;
  logic [DW-1:0] dw;
  logic [AW-1:0] wblock;
  logic          rd_start;
  logic [DW-1:0] dr;
  logic          rd_valid;
  logic          busy;
  logic          full;
  logic          empty;
  logic [AW-1:0] occ;
  logic [15:0]   ovf_cnt;

  int n_chk;
  int n_err;

  raw_buffer #(.DW(DW), .AW(AW), .MARGIN(10)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .dw       (dw),
    .wblock   (wblock),
    .rd_start (rd_start),
    .dr       (dr),
    .rd_valid (rd_valid),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .occ      (occ),
    .ovf_cnt  (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data word carries the index in both the low and high ends of the bus.
  function automatic logic [DW-1:0] mk(input int v);
    logic [31:0] x;
    x = v;
    return {x, {(DW-64){1'b0}}, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr(input int v);
    we = 1'b1;
    dw = mk(v);
    tick();
    we = 1'b0;
  endtask

  task automatic rd_block(input int len, input int first);
    wblock   = AW'(len - 1);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      check("blk_valid", DW'(rd_valid), DW'(1));
      check("blk_dr", dr, mk(first + i));
      tick();
    end
    check("blk_end_valid", DW'(rd_valid), DW'(0));
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    we       = 1'b0;
    dw       = '0;
    wblock   = '0;
    rd_start = 1'b0;
    tick();
    // Inputs asserted during reset must be ignored.
    we       = 1'b1;
    rd_start = 1'b1;
    tick();
    we       = 1'b0;
    rd_start = 1'b0;
    rst      = 1'b0;

    check("rst_valid", DW'(rd_valid), DW'(0));
    check("rst_busy",  DW'(busy),     DW'(0));
    check("rst_empty", DW'(empty),    DW'(1));
    check("rst_full",  DW'(full),     DW'(0));
    check("rst_occ",   DW'(occ),      DW'(0));
    check("rst_ovf",   DW'(ovf_cnt),  DW'(0));

    // Fill with one-word blocks until full.
    wblock = '0;
    for (int i = 0; i < 245; i++) wr(i);
    check("fill245_full", DW'(full), DW'(0));
    check("fill245_occ",  DW'(occ),  DW'(245));
    wr(245);
    check("fill246_full", DW'(full), DW'(1));
    check("fill246_occ",  DW'(occ),  DW'(246));
    for (int i = 0; i < 3; i++) wr(1000 + i);
    check("drop_occ",  DW'(occ),  DW'(246));
    check("drop_full", DW'(full), DW'(1));
`ifdef RAW_BUFFER_OVF_CNT_EN
    check("drop_ovf", DW'(ovf_cnt), DW'(3));
`else
    check("drop_ovf", DW'(ovf_cnt), DW'(0));
`endif
    rd_block(1, 0);
    check("one_out_occ",  DW'(occ),  DW'(245));
    check("one_out_full", DW'(full), DW'(0));
    do_reset();
    check("ovf_cleared", DW'(ovf_cnt), DW'(0));
    check("rst2_occ",    DW'(occ),     DW'(0));

    // Large wblock must not truncate the threshold.
    wblock = 8'd250;
    wr(7);
    check("wide_thr_full", DW'(full), DW'(1));
    check("wide_thr_occ",  DW'(occ),  DW'(1));
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("short_start_busy", DW'(busy), DW'(0));

    // Block of 4 with a stray rd_start mid-readout.
    do_reset();
    wblock = 8'd3;
    for (int i = 1; i <= 8; i++) wr(i);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b1_valid", DW'(rd_valid), DW'(1));
      check("b1_dr", dr, mk(i + 1));
      if (i == 1) rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
    end
    check("b1_busy",  DW'(busy),  DW'(0));
    check("b1_occ",   DW'(occ),   DW'(4));
    check("b1_empty", DW'(empty), DW'(0));

    // Changing wblock mid-readout must not alter the block length.
    wblock   = 8'd3;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2_valid", DW'(rd_valid), DW'(1));
      check("b2_dr", dr, mk(i + 5));
      if (i == 0) wblock = 8'd0;
      tick();
    end
    check("b2_busy",  DW'(busy),  DW'(0));
    check("b2_empty", DW'(empty), DW'(1));
    check("b2_occ",   DW'(occ),   DW'(0));

    // Walk the pointers up to the wrap point.
    do_reset();
    wblock = '0;
    for (int i = 0; i < 200; i++) wr(i);
    rd_block(200, 0);
    check("walk200_occ", DW'(occ), DW'(0));
    wblock = '0;
    for (int i = 200; i < 250; i++) wr(i);
    rd_block(50, 200);
    check("walk250_empty", DW'(empty), DW'(1));
    wblock = '0;
    for (int i = 250; i < 254; i++) wr(i);
    check("adw254_occ", DW'(occ), DW'(4));
    for (int i = 254; i < 258; i++) wr(i);
    check("wrap_occ", DW'(occ), DW'(8));
    rd_block(6, 250);
    check("adb0_occ",   DW'(occ),   DW'(2));
    check("adb0_empty", DW'(empty), DW'(0));
    rd_block(2, 256);
    check("wrap_done_empty", DW'(empty), DW'(1));

    // Reset on the third beat of a readout.
    wblock = '0;
    for (int i = 300; i < 304; i++) wr(i);
    wblock   = 8'd3;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    check("beat3_dr", dr, mk(302));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", DW'(rd_valid), DW'(0));
    check("midrst_busy",  DW'(busy),     DW'(0));
    check("midrst_occ",   DW'(occ),      DW'(0));
    check("midrst_empty", DW'(empty),    DW'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/raw_buffer.md
RAW_BUFFER -- requirements
Module: raw_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 672, data word width in bits.
- AW, 8, address width; depth is 2^AW words.
- MARGIN, 10, extra free words kept beyond one block before full asserts.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset, synchronous, active-high.
- we, in, 1, write strobe.
- dw, in, DW, write data.
- wblock, in, AW, block length minus 1.
- rd_start, in, 1, request readout of one block.
- dr, out, DW, read data.
- rd_valid, out, 1, dr holds a valid block word.
- busy, out, 1, readout in progress.
- full, out, 1, write side must stop.
- empty, out, 1, no stored words.
- occ, out, AW, stored-word count.
- ovf_cnt, out, 16, count of dropped writes.

Function
REQ-003 The block SHALL keep an AW-bit write pointer adw, base pointer adb and read address register adrr; all pointer arithmetic SHALL be modulo 2^AW.
REQ-004 occ SHALL equal (adw - adb) mod 2^AW; empty SHALL equal (adw == adb).
REQ-005 full SHALL equal NOT((diff > wblock + MARGIN) OR (adb == adw)), with diff = (adb - adw) mod 2^AW; wblock + MARGIN SHALL be evaluated at AW+2 bits with no wrap.
REQ-006 When we=1 and full=0, dw SHALL be written to mem[adw] and adw SHALL increment at that edge.
REQ-007 When we=1 and full=1, the write SHALL be dropped and adw SHALL be unchanged.
REQ-008 Memory SHALL be a synchronous-write array of 2^AW x DW, mapped to block RAM. dr SHALL equal mem[adrr], giving one cycle of read latency.
REQ-009 The FSM SHALL have two states, IDLE and READ.
REQ-010 In IDLE, rd_start=1 with occ >= wblock+1 SHALL have the following effects at that edge: latch wblock into blen, load adrr with adb, clear beat counter bc to 0, and enter READ. Otherwise rd_start SHALL be ignored.
REQ-011 In READ, rd_valid SHALL be 1 and dr SHALL equal mem[adb+bc]. Each edge SHALL increment adrr and bc.
REQ-012 When bc == blen in READ, the next edge SHALL advance adb by blen+1 and return the FSM to IDLE. rd_valid SHALL therefore be high for exactly blen+1 consecutive cycles.
REQ-013 busy SHALL equal (state == READ). rd_start while busy SHALL be ignored.
REQ-014 A write and an adb advance on the same edge SHALL both take effect. full, empty and occ SHALL reflect both from the next cycle.
REQ-015 A change of wblock during READ SHALL affect full only; the readout length SHALL stay blen.
REQ-016 Pointer wrap from 2^AW-1 to 0 SHALL be seamless for writes, reads and the adb advance.

Reset
REQ-017 rst=1 SHALL clear adw, adb, adrr, bc, blen and ovf_cnt, and force IDLE at the next edge, including mid-readout.
REQ-018 After reset the outputs SHALL be: rd_valid=0, busy=0, empty=1, full=0, occ=0, ovf_cnt=0. Memory contents SHALL NOT be cleared.
REQ-019 While rst=1, we and rd_start SHALL be ignored.

Configuration
REQ-020 With macro RAW_BUFFER_OVF_CNT_EN defined, ovf_cnt SHALL increment on each dropped write (REQ-007) and SHALL saturate at 0xFFFF.
REQ-021 Without RAW_BUFFER_OVF_CNT_EN, ovf_cnt SHALL be constant 0 and no counter logic SHALL be built. All other behaviour SHALL be identical in both builds.

Verification
All scenarios use the defaults DW=672, AW=8, MARGIN=10.
REQ-022 Reset, wblock=0, 246 writes -> full=0 after the 245th write and full=1 after the 246th; occ=246.
REQ-023 Continuing REQ-022, 3 more writes with the macro defined -> ovf_cnt=3, adw unchanged. With the macro undefined -> ovf_cnt=0.
REQ-024 Reset, wblock=250, one write -> full=1, because 250+10=260 is not truncated to 4.
REQ-025 Write 0x1, 0x2, 0x3, 0x4, then wblock=3 and rd_start -> rd_valid for 4 cycles starting the cycle after rd_start, dr = 1, 2, 3, 4, then busy=0, empty=1.
REQ-026 Fill to adw=254 with adb=250, then 4 writes, wblock=5 and rd_start -> dr reads addresses 250..255 with no wrap error, then adb=0. Last, assert rst on the 3rd beat of a readout -> rd_valid=0 and busy=0 on the next cycle, occ=0.
